// File: rtl/galaga_rom_loader.sv
// galaga_rom_loader: turns the ioctl download byte stream into buffered ROM writes and gates the core reset
module galaga_rom_loader #(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [16:0] ROM_SIZE   = 17'h10000,
    parameter int          ADDR_W     = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_downl,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              dn_ready,
    output logic              dn_wr,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              core_reset,
    output logic              loaded,
    output logic              range_err,
    output logic              ovf_err,
    output logic [16:0]       byte_count,
    output logic [15:0]       checksum
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state;
    logic [ADDR_W+7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic full, empty, in_range, start, push, pop;
    assign full = count == (PW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign in_range = ioctl_addr < {8'd0, ROM_SIZE};
    assign start = ioctl_downl && ioctl_index == ROM_INDEX;
    // full is judged on the occupancy at the start of the cycle, so a same-cycle pop never frees room
    assign push = state == LOAD && ioctl_wr && in_range && !full;
    assign pop = !empty && dn_ready;
    assign dn_wr = !empty;
    assign {dn_addr, dn_data} = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
    end
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
            range_err  <= 1'b0;
            ovf_err    <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            core_reset <= !(state == DONE && !start);
            loaded <= state == DONE && !start && !(range_err || ovf_err);
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= LOAD;
                    byte_count <= '0;
                    checksum   <= '0;
                    range_err  <= 1'b0;
                    ovf_err    <= 1'b0;
                end
                LOAD: begin
                    if (push) begin
                        byte_count <= byte_count == ROM_SIZE ? byte_count : byte_count + 1'b1;
                        checksum   <= checksum + 16'(ioctl_dout);
                    end
                    if (ioctl_wr && !in_range) range_err <= 1'b1;
                    if (ioctl_wr && in_range && full) ovf_err <= 1'b1;
                    if (!ioctl_downl) state <= FLUSH;
                end
                default: if (empty) state <= DONE;
            endcase
        end
    end
endmodule
